// File: rtl/volume_control.sv
`default_nettype none
// ============================================================================
// volume_control : Up/Down volume stepping with hold-to-repeat and mute toggle
// Rev 1.0
// ============================================================================
module volume_control #(
  parameter int unsigned DELAY    = 25000000,
  parameter int unsigned RATE     = 5000000,
  parameter logic [7:0]  STEP     = 8'd4,
  parameter logic [7:0]  MAX_VOL  = 8'd252,
  parameter logic [7:0]  INIT_VOL = 8'd128
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Up,
  input  logic       Down,
  input  logic       Mute,
  output logic [7:0] Volume,
  output logic       Muted,
  output logic       Changed
);

  localparam int unsigned CNT_W = ($clog2(DELAY) > 25) ? $clog2(DELAY) : 25;
  localparam logic [CNT_W-1:0] C_DELAY_LOAD = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0] C_RATE_LOAD  = CNT_W'(RATE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_up_q, dir_up_d;
  logic             up_1_q, down_1_q, mute_1_q;
  logic [7:0]       volume_q, volume_d;
  logic             muted_q, muted_d;
  logic             changed_q, changed_d;

  logic       press;
  logic       active_held;
  logic       other_held;
  logic       cnt_zero;
  logic       mute_rise;
  logic       step_en;
  logic       step_up;
  logic [8:0] sum9;
  logic [7:0] vol_up;
  logic [7:0] vol_down;

  assign press       = (Up | Down) & ~up_1_q & ~down_1_q;
  assign active_held = dir_up_q ? Up : Down;
  assign other_held  = dir_up_q ? Down : Up;
  assign cnt_zero    = (cnt_q == '0);
  assign mute_rise   = Mute & ~mute_1_q;

  // State register and all other flops
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dir_up_q  <= 1'b0;
      up_1_q    <= 1'b0;
      down_1_q  <= 1'b0;
      mute_1_q  <= 1'b0;
      volume_q  <= INIT_VOL;
      muted_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_up_q  <= dir_up_d;
      up_1_q    <= Up;
      down_1_q  <= Down;
      mute_1_q  <= Mute;
      volume_q  <= volume_d;
      muted_q   <= muted_d;
      changed_q <= changed_d;
    end
  end

  // Next-state logic; the opposing button always wins over release
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = (Up && Down) ? S_LOCK : S_HOLD;
      end
      S_HOLD: begin
        if (other_held)        state_d = S_LOCK;
        else if (!active_held) state_d = S_IDLE;
        else if (cnt_zero)     state_d = S_REPEAT;
      end
      S_REPEAT: begin
        if (other_held)        state_d = S_LOCK;
        else if (!active_held) state_d = S_IDLE;
      end
      S_LOCK: begin
        if (!Up && !Down) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: step decisions and delay counter
  always_comb begin
    step_en  = 1'b0;
    step_up  = dir_up_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (press && (Up != Down)) begin
          step_en  = 1'b1;
          step_up  = Up;
          dir_up_d = Up;
          cnt_d    = C_DELAY_LOAD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (other_held || !active_held) begin
          cnt_d = '0;
        end else if (cnt_zero) begin
          step_en = 1'b1;
          cnt_d   = C_RATE_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Saturating arithmetic; the 9-bit sum keeps the upper clamp wrap-free
  always_comb begin
    sum9     = {1'b0, volume_q} + {1'b0, STEP};
    vol_up   = (sum9 > {1'b0, MAX_VOL}) ? MAX_VOL : sum9[7:0];
    vol_down = (volume_q < STEP) ? 8'd0 : (volume_q - STEP);
    volume_d = volume_q;
    if (step_en) volume_d = step_up ? vol_up : vol_down;
    muted_d = muted_q;
    if (step_en)        muted_d = 1'b0;
    else if (mute_rise) muted_d = ~muted_q;
    changed_d = (volume_d != volume_q) || (muted_d != muted_q);
  end

  assign Volume  = volume_q;
  assign Muted   = muted_q;
  assign Changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_volume_control.sv
`default_nettype none
// ============================================================================
// tb_volume_control : randomized and directed checks against a hold-time model
// Rev 1.0
// ============================================================================
module tb_volume_control;

  localparam int DELAY    = 10;
  localparam int RATE     = 4;
  localparam int STEP     = 4;
  localparam int MAX_VOL  = 252;
  localparam int INIT_VOL = 128;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_LOCK = 3;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       Up, Down, Mute;
  logic [7:0] Volume;
  logic       Muted, Changed;

  int errors = 0;
  int checks = 0;

  int exp_vol;
  bit exp_muted, exp_changed;
  bit p_u, p_d, p_m;
  int mode;
  int held;

  volume_control #(
    .DELAY(DELAY), .RATE(RATE), .STEP(8'd4), .MAX_VOL(8'd252), .INIT_VOL(8'd128)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Up(Up), .Down(Down), .Mute(Mute),
    .Volume(Volume), .Muted(Muted), .Changed(Changed)
  );

  always #5 Clk = ~Clk;

  function automatic void model_reset();
    exp_vol = INIT_VOL; exp_muted = 0; exp_changed = 0;
    p_u = 0; p_d = 0; p_m = 0;
    mode = M_IDLE; held = 0;
  endfunction

  // One step at press, at DELAY cycles of holding, then every RATE cycles
  function automatic void model_step(bit u, bit d, bit m);
    bit step = 0;
    bit up = 0;
    bit act, oth, nm;
    int nv;
    case (mode)
      M_IDLE: if ((u || d) && !p_u && !p_d) begin
        if (u && d) mode = M_LOCK;
        else begin
          mode = u ? M_UP : M_DN; held = 0; step = 1; up = u;
        end
      end
      M_UP, M_DN: begin
        act = (mode == M_UP) ? u : d;
        oth = (mode == M_UP) ? d : u;
        up  = (mode == M_UP);
        if (oth) mode = M_LOCK;
        else if (!act) mode = M_IDLE;
        else begin
          held++;
          if (held == DELAY || (held > DELAY && (held - DELAY) % RATE == 0)) step = 1;
        end
      end
      default: if (!u && !d) mode = M_IDLE;
    endcase
    nv = exp_vol;
    if (step) begin
      if (up) nv = (exp_vol + STEP > MAX_VOL) ? MAX_VOL : exp_vol + STEP;
      else    nv = (exp_vol < STEP) ? 0 : exp_vol - STEP;
    end
    nm = step ? 1'b0 : ((m && !p_m) ? !exp_muted : exp_muted);
    exp_changed = (nv != exp_vol) || (nm != exp_muted);
    exp_vol = nv; exp_muted = nm;
    p_u = u; p_d = d; p_m = m;
  endfunction

  task automatic tick(input bit u, input bit d, input bit m);
    Up = u; Down = d; Mute = m;
    model_step(u, d, m);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Up = 0; Down = 0; Mute = 0;
    nReset = 0;
    model_reset();
    @(negedge Clk);
    nReset = 1;
  endtask

  task automatic test_reset();
    Up = 0; Down = 0; Mute = 0;
    nReset = 0;
    model_reset();
    #12;
    checks++;
    if (Volume !== 8'd128) begin errors++; $display("FAIL reset_volume: got %0d want 128", Volume); end
    checks++;
    if (Muted !== 1'b0) begin errors++; $display("FAIL reset_muted: got %b want 0", Muted); end
    checks++;
    if (Changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b want 0", Changed); end
    @(negedge Clk);
    nReset = 1;
  endtask

  task automatic test_tap();
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL tap cyc%0d: got %0d/%b/%b want %0d/%b/%b", i, Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
      if (i == 0) begin
        checks++;
        if (Volume !== 8'd132 || Changed !== 1'b1) begin
          errors++; $display("FAIL tap_first_step: got vol=%0d chg=%b want 132/1", Volume, Changed);
        end
      end
    end
    tick(0, 0, 0);
    checks++;
    if (Volume !== 8'd132 || Changed !== 1'b0) begin
      errors++; $display("FAIL tap_no_repeat: got vol=%0d chg=%b want 132/0", Volume, Changed);
    end
  endtask

  task automatic test_hold_repeat();
    int pulses[$];
    do_reset();
    for (int i = 0; i < DELAY + 2*RATE + 1; i++) begin
      tick(0, 1, 0);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL hold cyc%0d: got %0d/%b/%b want %0d/%b/%b", i, Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
      if (Changed === 1'b1) pulses.push_back(i);
    end
    tick(0, 0, 0);
    checks++;
    if (Volume !== 8'd112) begin errors++; $display("FAIL hold_final: got %0d want 112", Volume); end
    checks++;
    if (pulses.size() != 4 || pulses[0] != 0 || pulses[1] != DELAY ||
        pulses[2] != DELAY + RATE || pulses[3] != DELAY + 2*RATE) begin
      errors++; $display("FAIL hold_pulse_times: got %0d pulses (first %0d) want 4 at 0,%0d,%0d,%0d",
                         pulses.size(), (pulses.size() > 0) ? pulses[0] : -1, DELAY, DELAY+RATE, DELAY+2*RATE);
    end
  endtask

  task automatic test_saturate();
    int after = 0;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 160; i++) begin
      tick(1, 0, 0);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL sat cyc%0d: got %0d/%b/%b want %0d/%b/%b", i, Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
      if (seen && Changed === 1'b1) after++;
      if (exp_vol == 248) seen = 1;
    end
    tick(0, 0, 0);
    checks++;
    if (Volume !== 8'd252 || after != 1) begin
      errors++; $display("FAIL sat_limit: got vol=%0d pulses_after_248=%0d want 252/1", Volume, after);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 3 + DELAY + RATE + 2 + 3 + 2; i++) begin
      if (i < 3)                       tick(1, 0, 0);
      else if (i < 3 + DELAY + RATE + 2) tick(1, 1, 0);
      else if (i < 3 + DELAY + RATE + 5) tick(1, 0, 0);
      else                             tick(0, 0, 0);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL lock cyc%0d: got %0d/%b/%b want %0d/%b/%b", i, Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
    end
    checks++;
    if (Volume !== 8'd132) begin errors++; $display("FAIL lock_hold: got %0d want 132", Volume); end
    tick(1, 0, 0);
    checks++;
    if (Volume !== 8'd136 || Changed !== 1'b1) begin
      errors++; $display("FAIL lock_fresh_press: got vol=%0d chg=%b want 136/1", Volume, Changed);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_mute();
    do_reset();
    tick(0, 0, 1);
    checks++;
    if (Muted !== 1'b1 || Changed !== 1'b1 || Volume !== 8'd128) begin
      errors++; $display("FAIL mute_toggle: got %0d/%b/%b want 128/1/1", Volume, Muted, Changed);
    end
    tick(0, 0, 1);
    tick(0, 0, 1);
    checks++;
    if (Muted !== 1'b1 || Changed !== 1'b0) begin
      errors++; $display("FAIL mute_no_repeat: got muted=%b chg=%b want 1/0", Muted, Changed);
    end
    tick(0, 0, 0);
    tick(1, 0, 1);
    checks++;
    if (Muted !== 1'b0 || Volume !== 8'd132 || Changed !== 1'b1) begin
      errors++; $display("FAIL mute_step_wins: got %0d/%b/%b want 132/0/1", Volume, Muted, Changed);
    end
    tick(0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < DELAY + RATE + 2; i++) tick(1, 0, 0);
    #3;
    nReset = 0;
    #1;
    checks++;
    if (Volume !== 8'd128 || Muted !== 1'b0 || Changed !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %0d/%b/%b want 128/0/0", Volume, Muted, Changed);
    end
    model_reset();
    #2;
    nReset = 1;
    for (int i = 0; i < DELAY - 1; i++) begin
      tick(1, 0, 0);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL arst cyc%0d: got %0d/%b/%b want %0d/%b/%b", i, Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
    end
    checks++;
    if (Volume !== 8'd132) begin errors++; $display("FAIL arst_held_press: got %0d want 132", Volume); end
    tick(0, 0, 0);
  endtask

  task automatic test_random();
    bit u = 0, d = 0, m = 0;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)  u = ~u;
      if ($urandom_range(0, 11) == 0) d = ~d;
      if ($urandom_range(0, 5) == 0)  m = ~m;
      tick(u, d, m);
      checks++;
      if (Volume !== 8'(exp_vol) || Muted !== exp_muted || Changed !== exp_changed) begin
        errors++;
        $display("FAIL rand cyc%0d in=%b%b%b: got %0d/%b/%b want %0d/%b/%b", i, u, d, m,
                 Volume, Muted, Changed, exp_vol, exp_muted, exp_changed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_hold_repeat();
    test_saturate();
    test_lock();
    test_mute();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/volume_control.md
VOLUME_CONTROL -- requirements
Module: volume_control

Interface
REQ-001 The block SHALL have parameter DELAY, default 25000000, meaning cycles from first step to first auto-repeat step (500 ms at 50 MHz).
REQ-002 The block SHALL have parameter RATE, default 5000000, meaning cycles between auto-repeat steps (100 ms).
REQ-003 The block SHALL have parameter STEP, default 8'd4, meaning the volume increment/decrement per step.
REQ-004 The block SHALL have parameter MAX_VOL, default 8'd252, meaning the upper volume limit; the lower limit is 0.
REQ-005 The block SHALL have parameter INIT_VOL, default 8'd128, meaning the volume after reset.
REQ-006 The block SHALL have port Clk, input, 1 bit: the single 50 MHz clock.
REQ-007 The block SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port Up, input, 1 bit: debounced level, high while the volume-up button is held.
REQ-009 The block SHALL have port Down, input, 1 bit: debounced level, high while the volume-down button is held.
REQ-010 The block SHALL have port Mute, input, 1 bit: debounced level, high while the mute button is held.
REQ-011 The block SHALL have port Volume, output, 8 bits: the current volume level, registered.
REQ-012 The block SHALL have port Muted, output, 1 bit: the current mute state, registered.
REQ-013 The block SHALL have port Changed, output, 1 bit: a one-cycle pulse whenever Volume or Muted changes value.

Function
REQ-014 Inputs Up, Down and Mute SHALL each be registered once (Up_1, Down_1, Mute_1); all decisions SHALL use the current input together with its registered copy.
REQ-015 The FSM SHALL have states IDLE, HOLD, REPEAT and LOCK, plus one delay counter of at least 25 bits.
REQ-016 In IDLE, a press SHALL be Up=1 or Down=1 in a cycle where Up_1=0 and Down_1=0.
REQ-017 A press of exactly one button SHALL apply one step, load the counter with DELAY-1 and enter HOLD.
REQ-018 A press of both Up and Down in the same cycle SHALL enter LOCK with no step applied.
REQ-019 In HOLD, the counter SHALL decrement each cycle; at 0 with the same button still held, the block SHALL step, load RATE-1 and enter REPEAT.
REQ-020 In REPEAT, the counter SHALL decrement each cycle; at 0 with the button still held, the block SHALL step and reload RATE-1.
REQ-021 In HOLD or REPEAT, release of the active button SHALL return the FSM to IDLE on the next edge, and the counter SHALL be discarded.
REQ-022 In HOLD or REPEAT, assertion of the other button SHALL enter LOCK with no step applied.
REQ-023 LOCK SHALL remain until Up=0 and Down=0, then go to IDLE.
REQ-024 A step SHALL take effect on the clock edge ending the decision cycle; Volume and Changed SHALL reflect it one cycle later.
REQ-025 An up step SHALL set Volume to min(Volume+STEP, MAX_VOL), computed in 9 bits with no wrap-around.
REQ-026 A down step SHALL set Volume to max(Volume-STEP, 0), with no underflow.
REQ-027 A step at a limit SHALL leave Volume unchanged.
REQ-028 Every step SHALL clear Muted, including a step at a limit.
REQ-029 A rising edge on Mute (Mute=1, Mute_1=0) SHALL toggle Muted; the Mute input SHALL have no auto-repeat.
REQ-030 If a Mute edge and a step occur in the same cycle, the step SHALL win: Muted SHALL become 0 and the Volume step SHALL apply.
REQ-031 Changed SHALL assert for exactly one cycle after any edge on which Volume or Muted changes value, and SHALL NOT assert otherwise.

Reset
REQ-032 On nReset=0, the block SHALL immediately set Volume=INIT_VOL, Muted=0, Changed=0, state IDLE, counter=0 and all input registers=0, regardless of Clk.
REQ-033 A button still held when nReset is released SHALL be treated as a new press in the first cycle after release, because the input registers are 0.

Verification
REQ-034 Tap Up for 10 cycles from reset -> Volume 128->132 exactly one cycle after the press; Changed high for one cycle; no further step.
REQ-035 Hold Down for DELAY+2*RATE+1 cycles -> exactly 4 steps in total (128->112), occurring at the press, press+DELAY, and +RATE twice; each step accompanied by one Changed pulse.
REQ-036 Start with Volume=248 and hold Up through the repeat phase -> 252, then constant; Changed pulses once only.
REQ-037 Hold Up, then assert Down during HOLD -> no further steps; after both are released, release Down first: Volume unchanged; a fresh Up press steps normally.
REQ-038 Mute edge -> Muted=1 with Changed; press Up with a simultaneous Mute edge -> Muted=0 and Volume +4.
REQ-039 Assert nReset=0 mid-REPEAT between clock edges -> outputs return to 128/0/0 asynchronously; with Up held through release, one step to 132.
